// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the async FIFO write and read controllers.
//   ptr_t is the extended pointer (address bits plus one wrap bit) for the
//   default FIFO_DEPTH.
//   bin2gray / gray2bin convert between binary and Gray pointers. The
//   controllers using them must be built with the same depth as this package.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

    typedef logic [FIFO_PTR_W:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[FIFO_PTR_W] = g[FIFO_PTR_W];
        for (int i = FIFO_PTR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_ptr_sync.sv
// -----------------------------------------------------------------------------
// ptr_sync
//   Multi-bit flop-chain synchroniser for Gray-coded pointers crossing clock
//   domains. The first flop samples i_d directly, with no logic in front of it.
//   All stages reset asynchronously to 0.
// Ports
//   clk     in   1      destination-domain clock
//   rst_n   in   1      asynchronous active-low reset
//   i_d     in   Width  Gray pointer from the source domain
//   o_q     out  Width  synchronised pointer, SyncStages flops later
// -----------------------------------------------------------------------------
module ptr_sync #(
    parameter int Width      = 4,
    parameter int SyncStages = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    logic [Width-1:0] r_stage [SyncStages];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage[0] <= '0;
        end else begin
            r_stage[0] <= i_d;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < SyncStages; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stage[gi] <= '0;
                end else begin
                    r_stage[gi] <= r_stage[gi-1];
                end
            end
        end
    endgenerate

    assign o_q = r_stage[SyncStages-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
//   Write-side controller of the async FIFO; everything runs on clk_wr.
//   Keeps the binary/Gray write pointer, synchronises the read Gray pointer,
//   and produces full, level, overflow and (optionally) almost-full flags.
//   Optional feature macro: FIFO_ALMOST_FULL_EN (registered o_wr_almost_full);
//   without it o_wr_almost_full is tied to 0.
// Ports
//   clk_wr            in   1           write clock
//   rst_n             in   1           asynchronous active-low reset
//   i_wr_en           in   1           producer write request
//   i_rd_gray         in   PtrWidth+1  read pointer (Gray, clk_rd domain)
//   o_wr_accept       out  1           i_wr_en & ~o_wr_full (combinational)
//   o_wr_full         out  1           FIFO full, registered
//   o_wr_ptr          out  PtrWidth    RAM write address, registered
//   o_wr_gray         out  PtrWidth+1  write pointer (Gray), to clk_rd domain
//   o_wr_level        out  PtrWidth+1  occupancy seen from clk_wr, registered
//   o_wr_overflow     out  1           one-cycle pulse per rejected write
//   o_wr_almost_full  out  1           level >= AlmostFull (macro only)
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int Depth      = FIFO_DEPTH,
    parameter int PtrWidth   = $clog2(Depth),
    parameter int SyncStages = 2,
    parameter int AlmostFull = Depth - 2
) (
    input  logic                clk_wr,
    input  logic                rst_n,
    input  logic                i_wr_en,
    input  logic [PtrWidth:0]   i_rd_gray,
    output logic                o_wr_accept,
    output logic                o_wr_full,
    output logic [PtrWidth-1:0] o_wr_ptr,
    output logic [PtrWidth:0]   o_wr_gray,
    output logic [PtrWidth:0]   o_wr_level,
    output logic                o_wr_overflow,
    output logic                o_wr_almost_full
);

    logic [PtrWidth:0] r_wr_bin;
    logic [PtrWidth:0] r_wr_gray;
    logic [PtrWidth:0] r_level;
    logic              r_full;
    logic              r_overflow;

    logic              w_accept;
    logic [PtrWidth:0] w_rd_sync;
    logic [PtrWidth:0] w_rd_bin;
    logic [PtrWidth:0] w_wr_bin_nxt;
    logic [PtrWidth:0] w_wr_gray_nxt;
    logic [PtrWidth:0] w_full_gray;
    logic [PtrWidth:0] w_level_nxt;
    logic              w_full_nxt;

    ptr_sync #(
        .Width      (PtrWidth + 1),
        .SyncStages (SyncStages)
    ) u_rd_sync (
        .clk   (clk_wr),
        .rst_n (rst_n),
        .i_d   (i_rd_gray),
        .o_q   (w_rd_sync)
    );

    assign w_accept      = i_wr_en & ~r_full;
    assign w_wr_bin_nxt  = r_wr_bin + {{PtrWidth{1'b0}}, w_accept};
    assign w_wr_gray_nxt = bin2gray(w_wr_bin_nxt);
    assign w_rd_bin      = gray2bin(w_rd_sync);

    // Full when the write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that is the top two bits inverted.
    assign w_full_gray = {~w_rd_sync[PtrWidth:PtrWidth-1], w_rd_sync[PtrWidth-2:0]};
    assign w_full_nxt  = (w_wr_gray_nxt == w_full_gray);

    // The synchronised read pointer lags, so this can only over-report.
    assign w_level_nxt = w_wr_bin_nxt - w_rd_bin;

    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bin   <= '0;
            r_wr_gray  <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_bin   <= w_wr_bin_nxt;
            r_wr_gray  <= w_wr_gray_nxt;
            r_level    <= w_level_nxt;
            r_full     <= w_full_nxt;
            r_overflow <= i_wr_en & r_full;
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    logic r_almost_full;

    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_level_nxt >= (PtrWidth+1)'(AlmostFull));
        end
    end

    assign o_wr_almost_full = r_almost_full;
`else
    assign o_wr_almost_full = 1'b0;
`endif

    assign o_wr_accept   = w_accept;
    assign o_wr_full     = r_full;
    assign o_wr_ptr      = r_wr_bin[PtrWidth-1:0];
    assign o_wr_gray     = r_wr_gray;
    assign o_wr_level    = r_level;
    assign o_wr_overflow = r_overflow;

endmodule
